// File: rtl/iso_pwr_seq.sv
// rtl/iso_pwr_seq.sv - power-domain sequencer: isolation, retention, domain reset and power-switch control
// All outputs are registered from the next state, so none has a combinational path from an input.
module iso_pwr_seq #(
  parameter int ISO_SETTLE  = 2,
  parameter int SAVE_CYC    = 2,
  parameter int PWR_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic REQ_OFF,
  output logic ACK_OFF,
  input  logic PWR_ACK,
  output logic PWR_EN,
  output logic ISO_LH_EN,
  output logic ISO_HL_EN,
  output logic SAVE,
  output logic RESTORE,
  output logic DOM_RSTN,
  output logic BUSY,
  output logic ERR
);

  typedef enum logic [3:0] {
    S_ON, S_ISO, S_SAVE, S_RST, S_PDN, S_OFF,
    S_PUP, S_RREL, S_RESTORE, S_DEISO, S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] ISO_LOAD  = CNT_W'(ISO_SETTLE - 1);
  localparam logic [CNT_W-1:0] SAVE_LOAD = CNT_W'(SAVE_CYC - 1);
  localparam logic [CNT_W-1:0] PWR_LOAD  = CNT_W'(PWR_TIMEOUT - 1);

  state_t            state, nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              iso_nxt;

  function automatic logic [CNT_W-1:0] load_for(input state_t s);
    case (s)
      S_ISO, S_DEISO:     load_for = ISO_LOAD;
      S_SAVE, S_RESTORE:  load_for = SAVE_LOAD;
      S_PDN, S_PUP:       load_for = PWR_LOAD;
      default:            load_for = '0;
    endcase
  endfunction

  always_comb begin
    nxt     = state;
    cnt_nxt = (cnt == '0) ? '0 : cnt - 1'b1;
    case (state)
      S_ON:      if (REQ_OFF)      nxt = S_ISO;
      S_ISO:     if (cnt == '0)    nxt = S_SAVE;
      S_SAVE:    if (cnt == '0)    nxt = S_RST;
      S_RST:                       nxt = S_PDN;
      // Reaching the target level wins over an expiring timeout on the same cycle.
      S_PDN:     if (!PWR_ACK)     nxt = S_OFF;
                 else if (cnt == '0) nxt = S_ERR;
      S_OFF:     if (!REQ_OFF)     nxt = S_PUP;
      S_PUP:     if (PWR_ACK)      nxt = S_RREL;
                 else if (cnt == '0) nxt = S_ERR;
      S_RREL:                      nxt = S_RESTORE;
      S_RESTORE: if (cnt == '0)    nxt = S_DEISO;
      S_DEISO:   if (cnt == '0)    nxt = S_ON;
      default:                     nxt = S_ERR;
    endcase
    if (nxt != state) cnt_nxt = load_for(nxt);
    iso_nxt = !(nxt inside {S_ON, S_DEISO});
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= S_ON;
      cnt       <= '0;
      PWR_EN    <= 1'b1;
      ISO_LH_EN <= 1'b0;
      ISO_HL_EN <= 1'b1;
      SAVE      <= 1'b0;
      RESTORE   <= 1'b0;
      DOM_RSTN  <= 1'b1;
      ACK_OFF   <= 1'b0;
      BUSY      <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      state     <= nxt;
      cnt       <= cnt_nxt;
      PWR_EN    <= !(nxt inside {S_PDN, S_OFF, S_ERR});
      // Both clamp enables come from one term so they always flip on the same edge.
      ISO_LH_EN <= iso_nxt;
      ISO_HL_EN <= !iso_nxt;
      SAVE      <= (nxt == S_SAVE);
      RESTORE   <= (nxt == S_RESTORE);
      DOM_RSTN  <= !(nxt inside {S_RST, S_PDN, S_OFF, S_PUP, S_ERR});
      if (nxt != S_ERR) ACK_OFF <= (nxt == S_OFF);
      BUSY      <= !(nxt inside {S_ON, S_OFF, S_ERR});
      ERR       <= (nxt == S_ERR);
    end
  end

endmodule

// File: tb/tb_iso_pwr_seq.sv
// tb/tb_iso_pwr_seq.sv - scoreboard bench for iso_pwr_seq
// Output vector order: {PWR_EN, ISO_LH_EN, ISO_HL_EN, SAVE, RESTORE, DOM_RSTN, ACK_OFF, BUSY, ERR}.
module tb_iso_pwr_seq;

  localparam logic [8:0] V_ON    = 9'b1_0_1_0_0_1_0_0_0;
  localparam logic [8:0] V_ISO   = 9'b1_1_0_0_0_1_0_1_0;
  localparam logic [8:0] V_SAVE  = 9'b1_1_0_1_0_1_0_1_0;
  localparam logic [8:0] V_RST   = 9'b1_1_0_0_0_0_0_1_0;
  localparam logic [8:0] V_PDN   = 9'b0_1_0_0_0_0_0_1_0;
  localparam logic [8:0] V_OFF   = 9'b0_1_0_0_0_0_1_0_0;
  localparam logic [8:0] V_PUP   = 9'b1_1_0_0_0_0_0_1_0;
  localparam logic [8:0] V_RREL  = 9'b1_1_0_0_0_1_0_1_0;
  localparam logic [8:0] V_REST  = 9'b1_1_0_0_1_1_0_1_0;
  localparam logic [8:0] V_DEISO = 9'b1_0_1_0_0_1_0_1_0;
  localparam logic [8:0] V_ERR   = 9'b0_1_0_0_0_0_0_0_1;

  logic clk, rstn, req_off, pwr_ack, ack_off, pwr_en, iso_lh_en, iso_hl_en;
  logic save, restore, dom_rstn, busy, err;
  logic req2, ack2, ack_off2, pwr_en2, iso_lh2, iso_hl2, save2, restore2;
  logic dom_rstn2, busy2, err2;
  logic [8:0] o1, o2;
  logic [3:0] hist;
  logic stuck, mon_en;
  int dly;
  int n_total = 0;
  int n_pass = 0;

  typedef struct { int id; logic [8:0] v; int hold; } exp_t;
  exp_t q[$];
  logic [8:0] last [2];
  int run [2];
  int hold [2];

  iso_pwr_seq dut (
    .CLK(clk), .RSTN(rstn), .REQ_OFF(req_off), .ACK_OFF(ack_off), .PWR_ACK(pwr_ack),
    .PWR_EN(pwr_en), .ISO_LH_EN(iso_lh_en), .ISO_HL_EN(iso_hl_en), .SAVE(save),
    .RESTORE(restore), .DOM_RSTN(dom_rstn), .BUSY(busy), .ERR(err)
  );

  iso_pwr_seq #(.ISO_SETTLE(1), .SAVE_CYC(1)) dut2 (
    .CLK(clk), .RSTN(rstn), .REQ_OFF(req2), .ACK_OFF(ack_off2), .PWR_ACK(ack2),
    .PWR_EN(pwr_en2), .ISO_LH_EN(iso_lh2), .ISO_HL_EN(iso_hl2), .SAVE(save2),
    .RESTORE(restore2), .DOM_RSTN(dom_rstn2), .BUSY(busy2), .ERR(err2)
  );

  assign o1 = {pwr_en, iso_lh_en, iso_hl_en, save, restore, dom_rstn, ack_off, busy, err};
  assign o2 = {pwr_en2, iso_lh2, iso_hl2, save2, restore2, dom_rstn2, ack_off2, busy2, err2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-switch model: PWR_ACK follows PWR_EN after dly cycles, or sticks high.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) hist <= '1;
    else       hist <= {hist[2:0], pwr_en};
  end
  assign pwr_ack = stuck ? 1'b1 : hist[dly-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic push(input int id, input logic [8:0] v, input int h);
    exp_t e;
    e.id = id; e.v = v; e.hold = h;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [8:0] cur;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      cur = (i == 0) ? o1 : o2;
      if (!mon_en) begin
        last[i] = cur; run[i] = 0; hold[i] = -1;
      end else begin
        chk("iso_pair", 32'(cur[7] ^ cur[6]), 32'd1);
        if (cur !== last[i]) begin
          if (hold[i] >= 0) chk("hold_cycles", run[i], hold[i]);
          chk("expected_change", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("dut_id", i, e.id);
            chk("outputs", {23'd0, cur}, {23'd0, e.v});
            hold[i] = e.hold;
          end else begin
            hold[i] = -1;
          end
          last[i] = cur;
          run[i] = 1;
        end else begin
          run[i]++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rstn = 1'b0; req_off = 1'b0; req2 = 1'b0; ack2 = 1'b0;
    stuck = 1'b0; dly = 1; mon_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {23'd0, o1}, {23'd0, V_ON});
    chk("reset_state2", {23'd0, o2}, {23'd0, V_ON});
    rstn = 1'b1;
    @(posedge clk); #1 mon_en = 1'b1;
    @(negedge clk);

    // Power-down with a 1-cycle switch response.
    push(0, V_ISO, 2); push(0, V_SAVE, 2); push(0, V_RST, 1); push(0, V_PDN, 2); push(0, V_OFF, -1);
    req_off = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!ack_off && n < 40);
    chk("down_latency", n, 8);

    // Power-up with a 3-cycle switch response.
    repeat (4) @(negedge clk);
    dly = 3;
    push(0, V_PUP, 4); push(0, V_RREL, 1); push(0, V_REST, 2); push(0, V_DEISO, 2); push(0, V_ON, -1);
    req_off = 1'b0; n = 0;
    do begin @(negedge clk); n++; end while ((busy || ack_off) && n < 40);
    chk("up_latency", n, 10);
    repeat (4) @(negedge clk);
    dly = 1;

    // Request withdrawn during SAVE: down completes, one OFF cycle, then up.
    push(0, V_ISO, 2); push(0, V_SAVE, 2); push(0, V_RST, 1); push(0, V_PDN, 2); push(0, V_OFF, 1);
    push(0, V_PUP, 2); push(0, V_RREL, 1); push(0, V_REST, 2); push(0, V_DEISO, 2); push(0, V_ON, -1);
    req_off = 1'b1;
    repeat (3) @(negedge clk);
    req_off = 1'b0;
    repeat (25) @(negedge clk);
    chk("bounce_final_ack", ack_off, 0);

    // Switch never drops: timeout to ERR, sticky, cleared only by reset.
    push(0, V_ISO, 2); push(0, V_SAVE, 2); push(0, V_RST, 1); push(0, V_PDN, 64); push(0, V_ERR, -1);
    stuck = 1'b1; req_off = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!err && n < 200);
    chk("err_latency", n, 70);
    req_off = 1'b0;
    repeat (5) @(negedge clk);
    chk("err_sticky", {23'd0, o1}, {23'd0, V_ERR});
    push(0, V_ON, -1);
    @(posedge clk); #2 rstn = 1'b0;
    #1 chk("err_async_reset", {23'd0, o1}, {23'd0, V_ON});
    stuck = 1'b0;
    @(negedge clk); rstn = 1'b1;
    repeat (4) @(negedge clk);

    // Reset pulsed during RESTORE.
    push(0, V_ISO, 2); push(0, V_SAVE, 2); push(0, V_RST, 1); push(0, V_PDN, 2); push(0, V_OFF, -1);
    push(0, V_PUP, 2); push(0, V_RREL, 1); push(0, V_REST, -1); push(0, V_ON, -1);
    req_off = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!ack_off && n < 40);
    chk("wait_off", ack_off, 1);
    req_off = 1'b0; n = 0;
    do begin @(negedge clk); n++; end while (!restore && n < 40);
    chk("wait_restore", restore, 1);
    @(posedge clk); #2 rstn = 1'b0;
    #1 chk("restore_async_reset", {23'd0, o1}, {23'd0, V_ON});
    @(negedge clk); rstn = 1'b1;
    repeat (4) @(negedge clk);

    // Minimum settle/save build with switch already off on PDN entry.
    push(1, V_ISO, 1); push(1, V_SAVE, 1); push(1, V_RST, 1); push(1, V_PDN, 1); push(1, V_OFF, -1);
    req2 = 1'b1;
    repeat (12) @(negedge clk);
    chk("min_build_off", {23'd0, o2}, {23'd0, V_OFF});

    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/iso_pwr_seq.md
Name: iso_pwr_seq

Overview:
- Sequencer for one switchable power domain; produces the control side of the isolation cells at the domain boundary.
- Drives the clamp-high cell enable ISO_LH_EN and the clamp-low cell enable ISO_HL_EN.
  - IsoLH: Y = En | A, so active-high clamp.
  - IsoHL: Y = En & A, so active-low clamp.
- Also drives retention save/restore, domain reset and the power-switch enable.
- Sits in the always-on domain between the system power manager (level REQ/ACK) and the switched domain containing blocks such as BLKD/BLKE.

Parameters:
- ISO_SETTLE, 2, cycles isolation is held stable before save (down) and after de-isolate (up); min 1.
- SAVE_CYC, 2, cycles SAVE or RESTORE is held high; min 1.
- PWR_TIMEOUT, 64, max cycles to wait for PWR_ACK to follow PWR_EN.
- CNT_W, 8, counter width; must hold max(ISO_SETTLE, SAVE_CYC, PWR_TIMEOUT).

Ports:
- CLK  input  1  clock
- RSTN  input  1  asynchronous active-low reset
- REQ_OFF  input  1  level request from power manager: 1 = domain off, 0 = domain on
- ACK_OFF  output  1  level status: equals REQ_OFF once a sequence has completed
- PWR_ACK  input  1  power-switch chain feedback: 1 = domain powered; already synchronised
- PWR_EN  output  1  power-switch enable
- ISO_LH_EN  output  1  to IsoLH En; 1 = clamp output high
- ISO_HL_EN  output  1  to IsoHL En; 0 = clamp output low
- SAVE  output  1  retention save strobe
- RESTORE  output  1  retention restore strobe
- DOM_RSTN  output  1  domain reset, active low
- BUSY  output  1  1 while in any state other than ON, OFF, ERR
- ERR  output  1  sticky power-switch timeout flag

Behaviour:
- Reset (RSTN=0, async) forces state ON and these outputs:
  - PWR_EN=1, ISO_LH_EN=0, ISO_HL_EN=1, SAVE=0, RESTORE=0
  - DOM_RSTN=1, ACK_OFF=0, BUSY=0, ERR=0
- All outputs are registered and decoded from state; no combinational path from input to output.
- Isolation polarity: "isolated" means ISO_LH_EN=1 and ISO_HL_EN=0. The two always change on the same edge; never LH=0 with HL=0 held for a cycle.
- Single counter CNT, reloaded on every state entry.
- Power-down path, from ON when REQ_OFF=1 is sampled:
  - ISO: isolated; hold ISO_SETTLE cycles.
  - SAVE: SAVE=1; hold SAVE_CYC cycles.
  - RST: DOM_RSTN=0; 1 cycle.
  - PDN: PWR_EN=0; wait for PWR_ACK=0.
  - OFF: ACK_OFF=1.
- Power-up path, from OFF when REQ_OFF=0 is sampled:
  - PUP: PWR_EN=1; DOM_RSTN=0 and isolation kept; wait for PWR_ACK=1.
  - RREL: DOM_RSTN=1; 1 cycle.
  - RESTORE: RESTORE=1; hold SAVE_CYC cycles.
  - DEISO: ISO_LH_EN=0, ISO_HL_EN=1; hold ISO_SETTLE cycles.
  - ON: ACK_OFF=0.
- Isolation stays asserted in every state from ISO through DEISO entry, including OFF, PDN and PUP.
- DOM_RSTN=0 from RST through PUP, inclusive.
- REQ_OFF is sampled only in ON and OFF. Changes mid-sequence are ignored; if REQ_OFF differs from ACK_OFF after completion, the opposite sequence starts on the next cycle.
- Timeout: in PDN or PUP, if PWR_ACK has not reached the expected level after PWR_TIMEOUT cycles, go to ERR.
  - ERR outputs: ERR=1, BUSY=0, isolation asserted, DOM_RSTN=0, PWR_EN=0.
  - ERR is terminal until RSTN.
  - ACK_OFF holds its last value in ERR.
- PWR_ACK already at the target level on PDN/PUP entry: leave after 1 cycle.
- Glitch on PWR_ACK in OFF or ON is ignored, i.e. it is not monitored there.
- Reset asserted mid-sequence: immediate return to reset values. The power manager must re-request.

Test Plan:
- Power-down, defaults, PWR_ACK follows PWR_EN after 1 cycle, REQ_OFF 0->1 -> outputs in this order:
  - isolated for 2 cycles, then SAVE high 2 cycles, then DOM_RSTN low, then PWR_EN=0
  - ACK_OFF=1 exactly 8 cycles after REQ_OFF is sampled; BUSY high throughout.
- Power-up from OFF, REQ_OFF 1->0, PWR_ACK rises 3 cycles after PWR_EN -> required order:
  - PWR_EN=1, then DOM_RSTN=1, then RESTORE 2 cycles, then de-isolate
  - ACK_OFF=0; ISO_LH_EN=0 and ISO_HL_EN=1 flip on the same edge.
- REQ_OFF toggled 1->0 during SAVE -> down sequence completes (ACK_OFF=1 for exactly one cycle), then the up sequence starts automatically; final ACK_OFF=0.
- PWR_ACK stuck at 1 in PDN -> ERR=1 after 64 cycles; isolation held, DOM_RSTN=0; further REQ_OFF changes ignored; RSTN clears.
- RSTN pulsed low while in RESTORE -> all outputs at reset values asynchronously, state ON, ERR=0.
- ISO_SETTLE=1, SAVE_CYC=1 build with PWR_ACK already 0 on PDN entry -> PDN lasts 1 cycle; every power-down stage still occurs.
